// File: rtl/mem_defs.sv
// Memory-subsystem shared definitions: load queue FSM encoding, issue and
// memory-pipe packet layouts, and the ROB age-compare helper.
package mem_defs;

    localparam int LDQ_NUM_ENTRIES = 16;
    localparam int LDQ_ID_W        = 4;
    localparam int STQ_NUM_ENTRIES = 8;
    localparam int ROB_IDX_W       = 6;
    localparam int XLEN            = 64;
    localparam int VADDR_W         = 40;
    localparam int PREG_W          = 7;
    localparam int SIMID_W         = 16;

    typedef logic [LDQ_ID_W-1:0]  t_ldq_id;
    // MSB is the wrap bit, low bits are the ROB slot index
    typedef logic [ROB_IDX_W:0]   t_rob_id;
    typedef logic [VADDR_W-1:0]   t_vaddr;
    typedef logic [PREG_W-1:0]    t_preg;
    typedef logic [SIMID_W-1:0]   t_simid;

    typedef struct packed {
        logic    valid;
        t_rob_id robid;
    } t_nuke_pkt;

    typedef struct packed {
        t_rob_id robid;
        t_simid  simid;
    } t_ldq_static;

    typedef struct packed {
        t_ldq_id ldqid;
    } t_mem_meta;

    typedef struct packed {
        t_mem_meta mem;
    } t_iss_meta;

    typedef struct packed {
        t_iss_meta       meta;
        logic [XLEN-1:0] src1_val;
        logic [XLEN-1:0] src2_val;
        t_preg           pdst;
        t_simid          simid;
    } t_iss_pkt;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_FILL  = 2'd3
    } t_mempipe_arb_type;

    typedef struct packed {
        t_mempipe_arb_type arb_type;
        t_ldq_id           id;
        t_vaddr            addr;
        t_rob_id           robid;
        t_preg             pdst;
        logic              yost;
        t_simid            simid;
    } t_mempipe_arb;

    typedef struct packed {
        logic complete;
        logic recycle;
    } t_mempipe_action;

    typedef enum logic [2:0] {
        LDQ_IDLE     = 3'd0,
        LDQ_PDG_ISS  = 3'd1,
        LDQ_REQ_PIPE = 3'd2,
        LDQ_PDG_PIPE = 3'd3,
        LDQ_WAIT     = 3'd4,
        LDQ_DRAIN    = 3'd5
    } t_ldq_fsm;

    // True when a is strictly older than b; differing wrap bits invert the index order
    function automatic logic rob_older(input t_rob_id a, input t_rob_id b);
        return (a[ROB_IDX_W] != b[ROB_IDX_W]) ^ (a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0]);
    endfunction

endpackage

// File: rtl/loadq_entry_mp_backoff.sv
// Recycle backoff down-counter: loads 2^min(rcy_cnt, RCY_W-1) - 1 and counts
// to zero. Only instantiated when LDQ_RCY_BACKOFF_EN is defined.
module ldq_backoff_ctr #(
    parameter int RCY_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [RCY_W-1:0] rcy_cnt,
    output logic             expired
);

    localparam logic [RCY_W-1:0] MAX_SHIFT = RCY_W'(RCY_W - 1);

    logic [RCY_W-1:0] cnt_q, cnt_d;
    logic [RCY_W-1:0] shamt;

    // Next count: reload on WAIT entry, otherwise count down and hold at zero
    always_comb begin
        shamt = (rcy_cnt > MAX_SHIFT) ? MAX_SHIFT : rcy_cnt;
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (RCY_W'(1) << shamt) - RCY_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/loadq_entry_mp.sv
// Load queue entry (second generation): tracks one load from allocation to
// completion. Optional recycle backoff is enabled with LDQ_RCY_BACKOFF_EN;
// the SIMID field of the request packet is filled only under SIMULATION.
module loadq_entry_mp
    import mem_defs::*;
#(
    parameter int NUM_ISS = 2,
    parameter int NUM_STQ = STQ_NUM_ENTRIES,
    parameter int RCY_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  t_ldq_id                    id,
    input  t_nuke_pkt                  nuke_rb1,
    input  logic [NUM_STQ-1:0]         stq_e_valid,
    input  logic                       e_alloc_rs0,
    input  t_ldq_static                q_alloc_static_rs0,
    output logic                       e_valid,
    output t_ldq_static                e_static,
    output logic                       e_dealloc,
    output logic [RCY_W-1:0]           e_rcy_cnt,
    input  logic [NUM_ISS-1:0]         iss_ql_mm0,
    input  t_iss_pkt [NUM_ISS-1:0]     iss_pkt_mm0,
    output logic                       e_pipe_req_mm0,
    output t_mempipe_arb               e_pipe_req_pkt_mm0,
    input  logic                       e_pipe_gnt_mm0,
    input  logic                       pipe_valid_mm5,
    input  t_mempipe_arb               pipe_req_pkt_mm5,
    input  t_mempipe_action            pipe_action_mm5
);

    t_ldq_fsm           state_q, state_d;
    t_ldq_static        e_static_q, e_static_d;
    logic [NUM_STQ-1:0] e_stq_elders_q, e_stq_elders_d;
    t_vaddr             e_addr_q, e_addr_d;
    t_preg              e_pdst_q, e_pdst_d;
    logic [RCY_W-1:0]   e_rcy_cnt_q, e_rcy_cnt_d;
    logic               e_dealloc_q, e_dealloc_d;
    t_mempipe_arb       req_pkt_q, req_pkt_d;

    logic [NUM_ISS-1:0] iss_hit_vec;
    logic               iss_hit;
    t_iss_pkt           iss_sel;
    logic               alloc_ok;
    logic               nuke_hit;
    logic               act_hit;
    logic               act_complete;
    logic               act_recycle;
    logic               rcy_take;
    logic               bo_expired;
    logic               unused_inputs;

    assign e_valid = (state_q != LDQ_IDLE);

    // Event decode: issue match (lowest port wins), nuke age check, mm5 action
    always_comb begin
        iss_hit_vec = '0;
        iss_sel     = '0;
        for (int p = 0; p < NUM_ISS; p++) begin
            iss_hit_vec[p] = iss_ql_mm0[p] && (iss_pkt_mm0[p].meta.mem.ldqid == id);
        end
        for (int p = NUM_ISS - 1; p >= 0; p--) begin
            if (iss_hit_vec[p]) begin
                iss_sel = iss_pkt_mm0[p];
            end
        end
        iss_hit      = |iss_hit_vec;
        alloc_ok     = (state_q == LDQ_IDLE) && e_alloc_rs0;
        nuke_hit     = nuke_rb1.valid && e_valid && !rob_older(e_static_q.robid, nuke_rb1.robid);
        act_hit      = pipe_valid_mm5 && (pipe_req_pkt_mm5.arb_type == MEM_LOAD) &&
                       (pipe_req_pkt_mm5.id == id);
        act_complete = act_hit && pipe_action_mm5.complete;
        act_recycle  = act_hit && pipe_action_mm5.recycle && !pipe_action_mm5.complete;
        rcy_take     = (state_q == LDQ_PDG_PIPE) && act_recycle && !nuke_hit;
    end

    // Next-state logic; nuke outranks mm5 action, which outranks grant and issue
    always_comb begin
        state_d = state_q;
        case (state_q)
            LDQ_IDLE: begin
                if (e_alloc_rs0) state_d = LDQ_PDG_ISS;
            end
            LDQ_PDG_ISS: begin
                if (nuke_hit)     state_d = LDQ_IDLE;
                else if (iss_hit) state_d = LDQ_REQ_PIPE;
            end
            LDQ_REQ_PIPE: begin
                if (nuke_hit)            state_d = e_pipe_gnt_mm0 ? LDQ_DRAIN : LDQ_IDLE;
                else if (e_pipe_gnt_mm0) state_d = LDQ_PDG_PIPE;
            end
            LDQ_PDG_PIPE: begin
                if (nuke_hit)          state_d = act_hit ? LDQ_IDLE : LDQ_DRAIN;
                else if (act_complete) state_d = LDQ_IDLE;
                else if (act_recycle)  state_d = LDQ_WAIT;
            end
            LDQ_WAIT: begin
                if (nuke_hit)        state_d = LDQ_IDLE;
                else if (bo_expired) state_d = LDQ_REQ_PIPE;
            end
            LDQ_DRAIN: begin
                if (act_hit) state_d = LDQ_IDLE;
            end
            default: state_d = LDQ_IDLE;
        endcase
    end

    // Captured payload, store elders, recycle count, dealloc pulse and request packet
    always_comb begin
        e_static_d     = alloc_ok ? q_alloc_static_rs0 : e_static_q;
        e_stq_elders_d = alloc_ok ? stq_e_valid : (e_stq_elders_q & stq_e_valid);
        e_addr_d       = e_addr_q;
        e_pdst_d       = e_pdst_q;
        if ((state_q == LDQ_PDG_ISS) && iss_hit && !nuke_hit) begin
            e_addr_d = t_vaddr'(iss_sel.src1_val + iss_sel.src2_val);
            e_pdst_d = iss_sel.pdst;
        end
        e_rcy_cnt_d = e_rcy_cnt_q;
        if (alloc_ok) begin
            e_rcy_cnt_d = '0;
        end else if (rcy_take && (e_rcy_cnt_q != '1)) begin
            e_rcy_cnt_d = e_rcy_cnt_q + 1'b1;
        end
        e_dealloc_d        = (state_d == LDQ_IDLE) && (state_q != LDQ_IDLE);
        req_pkt_d          = '0;
        req_pkt_d.arb_type = MEM_LOAD;
        req_pkt_d.id       = id;
        req_pkt_d.addr     = e_addr_d;
        req_pkt_d.robid    = e_static_d.robid;
        req_pkt_d.pdst     = e_pdst_d;
        req_pkt_d.yost     = 1'b0;
`ifdef SIMULATION
        req_pkt_d.simid    = e_static_d.simid;
`endif
    end

    // State and payload registers; reset aborts immediately with no drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= LDQ_IDLE;
            e_static_q     <= '0;
            e_stq_elders_q <= '0;
            e_addr_q       <= '0;
            e_pdst_q       <= '0;
            e_rcy_cnt_q    <= '0;
            e_dealloc_q    <= 1'b0;
            req_pkt_q      <= '0;
        end else begin
            state_q        <= state_d;
            e_static_q     <= e_static_d;
            e_stq_elders_q <= e_stq_elders_d;
            e_addr_q       <= e_addr_d;
            e_pdst_q       <= e_pdst_d;
            e_rcy_cnt_q    <= e_rcy_cnt_d;
            e_dealloc_q    <= e_dealloc_d;
            req_pkt_q      <= req_pkt_d;
        end
    end

`ifdef LDQ_RCY_BACKOFF_EN
    logic bo_load;

    // Reload the backoff counter on every entry into WAIT
    always_comb begin
        bo_load = (state_d == LDQ_WAIT) && (state_q != LDQ_WAIT);
    end

    ldq_backoff_ctr #(
        .RCY_W   (RCY_W)
    ) u_backoff (
        .clk     (clk),
        .reset   (reset),
        .load    (bo_load),
        .rcy_cnt (e_rcy_cnt_d),
        .expired (bo_expired)
    );
`else
    assign bo_expired = 1'b1;
`endif

    assign e_static           = e_static_q;
    assign e_dealloc          = e_dealloc_q;
    assign e_rcy_cnt          = e_rcy_cnt_q;
    assign e_pipe_req_pkt_mm0 = req_pkt_q;
    assign e_pipe_req_mm0     = (state_q == LDQ_REQ_PIPE) && !nuke_hit && !(|e_stq_elders_q);

    assign unused_inputs = ^{iss_sel.meta, pipe_req_pkt_mm5.addr, pipe_req_pkt_mm5.robid,
                             pipe_req_pkt_mm5.pdst, pipe_req_pkt_mm5.yost, pipe_req_pkt_mm5.simid};

    // Protocol checks. A grant racing a nuke in REQ_PIPE is legal: the
    // arbiter may not see the request drop before it grants.
    a_one_issue_hit: assert property (@(posedge clk) disable iff (reset) $onehot0(iss_hit_vec));
    a_issue_state:   assert property (@(posedge clk) disable iff (reset)
                                      iss_hit |-> (state_q == LDQ_PDG_ISS));
    a_gnt_has_req:   assert property (@(posedge clk) disable iff (reset)
                                      e_pipe_gnt_mm0 |-> (e_pipe_req_mm0 ||
                                      ((state_q == LDQ_REQ_PIPE) && nuke_hit)));
    a_issue_simid:   assert property (@(posedge clk) disable iff (reset)
                                      (iss_hit && (state_q == LDQ_PDG_ISS)) |->
                                      (iss_sel.simid == e_static_q.simid));
    a_alloc_free:    assert property (@(posedge clk) disable iff (reset)
                                      e_alloc_rs0 |-> !e_valid);
    a_alloc_nuke:    assert property (@(posedge clk) disable iff (reset)
                                      e_alloc_rs0 |-> !nuke_rb1.valid);

endmodule

// File: tb/tb_loadq_entry_mp.sv
// Self-checking bench for loadq_entry_mp. Expected request packets are pushed
// to a scoreboard when issue/recycle stimulus is driven and popped when the
// entry raises its pipe request. Honours LDQ_RCY_BACKOFF_EN for WAIT lengths.
module tb_loadq_entry_mp;
    import mem_defs::*;

    localparam int NUM_ISS = 2;
    localparam int NUM_STQ = STQ_NUM_ENTRIES;
    localparam int RCY_W   = 4;
    localparam t_ldq_id MY_ID    = 4'd3;
    localparam t_ldq_id OTHER_ID = 4'd4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    t_nuke_pkt              nuke_rb1 = '0;
    logic [NUM_STQ-1:0]     stq_e_valid = '0;
    logic                   e_alloc_rs0 = 1'b0;
    t_ldq_static            q_alloc_static_rs0 = '0;
    logic                   e_valid;
    t_ldq_static            e_static;
    logic                   e_dealloc;
    logic [RCY_W-1:0]       e_rcy_cnt;
    logic [NUM_ISS-1:0]     iss_ql_mm0 = '0;
    t_iss_pkt [NUM_ISS-1:0] iss_pkt_mm0 = '0;
    logic                   e_pipe_req_mm0;
    t_mempipe_arb           e_pipe_req_pkt_mm0;
    logic                   e_pipe_gnt_mm0 = 1'b0;
    logic                   pipe_valid_mm5 = 1'b0;
    t_mempipe_arb           pipe_req_pkt_mm5 = '0;
    t_mempipe_action        pipe_action_mm5 = '0;

    int           n_cmp = 0;
    int           n_bad = 0;
    t_mempipe_arb sb_q[$];
    t_mempipe_arb exp_pkt;
    t_ldq_static  cur_static;
    bit           ok;

    loadq_entry_mp #(
        .NUM_ISS            (NUM_ISS),
        .NUM_STQ            (NUM_STQ),
        .RCY_W              (RCY_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .id                 (MY_ID),
        .nuke_rb1           (nuke_rb1),
        .stq_e_valid        (stq_e_valid),
        .e_alloc_rs0        (e_alloc_rs0),
        .q_alloc_static_rs0 (q_alloc_static_rs0),
        .e_valid            (e_valid),
        .e_static           (e_static),
        .e_dealloc          (e_dealloc),
        .e_rcy_cnt          (e_rcy_cnt),
        .iss_ql_mm0         (iss_ql_mm0),
        .iss_pkt_mm0        (iss_pkt_mm0),
        .e_pipe_req_mm0     (e_pipe_req_mm0),
        .e_pipe_req_pkt_mm0 (e_pipe_req_pkt_mm0),
        .e_pipe_gnt_mm0     (e_pipe_gnt_mm0),
        .pipe_valid_mm5     (pipe_valid_mm5),
        .pipe_req_pkt_mm5   (pipe_req_pkt_mm5),
        .pipe_action_mm5    (pipe_action_mm5)
    );

    always #5 clk = ~clk;

    function automatic t_mempipe_arb model_pkt(input t_ldq_static st, input logic [XLEN-1:0] s1,
                                               input logic [XLEN-1:0] s2, input t_preg pdst);
        t_mempipe_arb p;
        p          = '0;
        p.arb_type = MEM_LOAD;
        p.id       = MY_ID;
        p.addr     = t_vaddr'(s1 + s2);
        p.robid    = st.robid;
        p.pdst     = pdst;
`ifdef SIMULATION
        p.simid    = st.simid;
`endif
        return p;
    endfunction

    function automatic int model_wait_len(input int cnt);
`ifdef LDQ_RCY_BACKOFF_EN
        return 1 << ((cnt > RCY_W - 1) ? RCY_W - 1 : cnt);
`else
        return (cnt >= 0) ? 1 : 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input t_rob_id robid, input t_simid simid, input logic [NUM_STQ-1:0] stq);
        cur_static.robid   = robid;
        cur_static.simid   = simid;
        e_alloc_rs0        = 1'b1;
        q_alloc_static_rs0 = cur_static;
        stq_e_valid        = stq;
        tick();
        e_alloc_rs0        = 1'b0;
    endtask

    task automatic do_issue(input int port, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                            input t_preg pdst);
        t_iss_pkt mine, other;
        mine                = '0;
        mine.meta.mem.ldqid = MY_ID;
        mine.src1_val       = s1;
        mine.src2_val       = s2;
        mine.pdst           = pdst;
        mine.simid          = cur_static.simid;
        other               = mine;
        other.meta.mem.ldqid = OTHER_ID;
        other.src1_val      = 64'hdead_0000;
        iss_ql_mm0          = '1;
        iss_pkt_mm0[port]   = mine;
        iss_pkt_mm0[1-port] = other;
        sb_q.push_back(model_pkt(cur_static, s1, s2, pdst));
        tick();
        iss_ql_mm0          = '0;
    endtask

    task automatic do_grant();
        e_pipe_gnt_mm0 = 1'b1;
        tick();
        e_pipe_gnt_mm0 = 1'b0;
    endtask

    task automatic do_mm5(input logic complete, input logic recycle);
        pipe_valid_mm5            = 1'b1;
        pipe_req_pkt_mm5          = '0;
        pipe_req_pkt_mm5.arb_type = MEM_LOAD;
        pipe_req_pkt_mm5.id       = MY_ID;
        pipe_action_mm5.complete  = complete;
        pipe_action_mm5.recycle   = recycle;
        tick();
        pipe_valid_mm5            = 1'b0;
        pipe_action_mm5           = '0;
    endtask

    task automatic wait_req(output bit seen);
        int k = 0;
        while (!e_pipe_req_mm0 && k < 64) begin
            tick();
            k++;
        end
        seen = e_pipe_req_mm0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (e_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", e_valid); end
        n_cmp++; if (e_pipe_req_mm0 !== 1'b0 || e_dealloc !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req_dealloc: got %b%b want 00", e_pipe_req_mm0, e_dealloc); end
        n_cmp++; if (e_rcy_cnt !== '0) begin n_bad++; $display("[TB] FAIL reset_rcy: got %0d want 0", e_rcy_cnt); end
        n_cmp++; if (e_static !== '0 || e_pipe_req_pkt_mm0 !== '0) begin n_bad++; $display("[TB] FAIL reset_static_pkt: got %h/%h want 0/0", e_static, e_pipe_req_pkt_mm0); end
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        do_alloc(7'd5, 16'h1234, '0);
        n_cmp++; if (e_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_alloc_valid: got %b want 1", e_valid); end
        n_cmp++; if (e_static !== cur_static) begin n_bad++; $display("[TB] FAIL basic_static: got %h want %h", e_static, cur_static); end
        do_issue(1, 64'h1000, 64'h20, 7'h11);
        n_cmp++; if (e_pipe_req_mm0 !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_req_latency: got %b want 1", e_pipe_req_mm0); end
        exp_pkt = sb_q.pop_front();
        n_cmp++; if (e_pipe_req_pkt_mm0 !== exp_pkt) begin n_bad++; $display("[TB] FAIL basic_pkt: got %h want %h", e_pipe_req_pkt_mm0, exp_pkt); end
        do_grant();
        n_cmp++; if (e_pipe_req_mm0 !== 1'b0 || e_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_pdg_pipe: got req=%b valid=%b want 0/1", e_pipe_req_mm0, e_valid); end
        do_mm5(1'b1, 1'b1);
        n_cmp++; if (e_valid !== 1'b0 || e_dealloc !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_complete: got valid=%b dealloc=%b want 0/1", e_valid, e_dealloc); end
        tick();
        n_cmp++; if (e_dealloc !== 1'b0 || e_rcy_cnt !== '0) begin n_bad++; $display("[TB] FAIL basic_dealloc_pulse: got dealloc=%b rcy=%0d want 0/0", e_dealloc, e_rcy_cnt); end
    endtask

    task automatic test_stq_elders();
        do_alloc(7'd20, 16'h2222, 8'b0000_0110);
        do_issue(0, 64'h4000, 64'h8, 7'h22);
        n_cmp++; if (e_pipe_req_mm0 !== 1'b0) begin n_bad++; $display("[TB] FAIL elders_block0: got %b want 0", e_pipe_req_mm0); end
        stq_e_valid = 8'b0000_0100;
        tick();
        n_cmp++; if (e_pipe_req_mm0 !== 1'b0) begin n_bad++; $display("[TB] FAIL elders_block1: got %b want 0", e_pipe_req_mm0); end
        stq_e_valid = 8'b0000_0010;
        tick();
        n_cmp++; if (e_pipe_req_mm0 !== 1'b1) begin n_bad++; $display("[TB] FAIL elders_no_retrack: got %b want 1", e_pipe_req_mm0); end
        exp_pkt = sb_q.pop_front();
        n_cmp++; if (e_pipe_req_pkt_mm0 !== exp_pkt) begin n_bad++; $display("[TB] FAIL elders_pkt: got %h want %h", e_pipe_req_pkt_mm0, exp_pkt); end
        stq_e_valid = '0;
        do_grant();
        do_mm5(1'b1, 1'b0);
        n_cmp++; if (e_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL elders_done: got %b want 0", e_valid); end
    endtask

    task automatic test_nuke_drain();
        do_alloc(7'd10, 16'h3333, '0);
        do_issue(1, 64'h100, 64'h1, 7'h33);
        wait_req(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL drain_req_timeout: got 0 want 1"); end
        exp_pkt = sb_q.pop_front();
        n_cmp++; if (e_pipe_req_pkt_mm0 !== exp_pkt) begin n_bad++; $display("[TB] FAIL drain_pkt: got %h want %h", e_pipe_req_pkt_mm0, exp_pkt); end
        do_grant();
        nuke_rb1.valid = 1'b1;
        nuke_rb1.robid = 7'd8;
        tick();
        nuke_rb1 = '0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (e_valid !== 1'b1 || e_pipe_req_mm0 !== 1'b0) begin n_bad++; $display("[TB] FAIL drain_hold%0d: got valid=%b req=%b want 1/0", i, e_valid, e_pipe_req_mm0); end
            tick();
        end
        do_mm5(1'b0, 1'b1);
        n_cmp++; if (e_valid !== 1'b0 || e_dealloc !== 1'b1) begin n_bad++; $display("[TB] FAIL drain_exit: got valid=%b dealloc=%b want 0/1", e_valid, e_dealloc); end
        n_cmp++; if (e_rcy_cnt !== '0) begin n_bad++; $display("[TB] FAIL drain_rcy: got %0d want 0", e_rcy_cnt); end
    endtask

    task automatic test_nuke_young_and_kill();
        t_rob_id young[2];
        young[0] = 7'd12;
        young[1] = 7'h42;
        do_alloc(7'd10, 16'h4444, '0);
        for (int i = 0; i < 2; i++) begin
            nuke_rb1.valid = 1'b1;
            nuke_rb1.robid = young[i];
            tick();
            nuke_rb1 = '0;
            n_cmp++; if (e_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL young_nuke%0d: got %b want 1", i, e_valid); end
        end
        do_issue(0, 64'h7000, 64'h70, 7'h44);
        wait_req(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL young_req_timeout: got 0 want 1"); end
        exp_pkt = sb_q.pop_front();
        n_cmp++; if (e_pipe_req_pkt_mm0 !== exp_pkt) begin n_bad++; $display("[TB] FAIL young_pkt: got %h want %h", e_pipe_req_pkt_mm0, exp_pkt); end
        nuke_rb1.valid = 1'b1;
        nuke_rb1.robid = 7'd10;
        #1;
        n_cmp++; if (e_pipe_req_mm0 !== 1'b0) begin n_bad++; $display("[TB] FAIL kill_req_comb: got %b want 0", e_pipe_req_mm0); end
        tick();
        nuke_rb1 = '0;
        n_cmp++; if (e_valid !== 1'b0 || e_dealloc !== 1'b1) begin n_bad++; $display("[TB] FAIL kill_idle: got valid=%b dealloc=%b want 0/1", e_valid, e_dealloc); end
    endtask

    task automatic test_recycle();
        int exp_cnt = 0;
        int len;
        do_alloc(7'd30, 16'h5555, '0);
        do_issue(1, 64'h2_0000, 64'h44, 7'h55);
        for (int r = 0; r < 16; r++) begin
            wait_req(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL rcy%0d_req_timeout: got 0 want 1", r); end
            exp_pkt = sb_q.pop_front();
            n_cmp++; if (e_pipe_req_pkt_mm0 !== exp_pkt) begin n_bad++; $display("[TB] FAIL rcy%0d_pkt: got %h want %h", r, e_pipe_req_pkt_mm0, exp_pkt); end
            do_grant();
            sb_q.push_back(exp_pkt);
            do_mm5(1'b0, 1'b1);
            exp_cnt = (exp_cnt == (1 << RCY_W) - 1) ? exp_cnt : exp_cnt + 1;
            n_cmp++; if (e_rcy_cnt !== RCY_W'(exp_cnt)) begin n_bad++; $display("[TB] FAIL rcy%0d_cnt: got %0d want %0d", r, e_rcy_cnt, exp_cnt); end
            len = 0;
            while (!e_pipe_req_mm0 && len < 64) begin
                len++;
                tick();
            end
            n_cmp++; if (len != model_wait_len(exp_cnt)) begin n_bad++; $display("[TB] FAIL rcy%0d_wait_len: got %0d want %0d", r, len, model_wait_len(exp_cnt)); end
        end
        wait_req(ok);
        exp_pkt = sb_q.pop_front();
        n_cmp++; if (!ok || e_pipe_req_pkt_mm0 !== exp_pkt) begin n_bad++; $display("[TB] FAIL rcy_final_pkt: got %b/%h want 1/%h", ok, e_pipe_req_pkt_mm0, exp_pkt); end
        do_grant();
        do_mm5(1'b1, 1'b0);
        n_cmp++; if (e_valid !== 1'b0 || e_dealloc !== 1'b1) begin n_bad++; $display("[TB] FAIL rcy_complete: got valid=%b dealloc=%b want 0/1", e_valid, e_dealloc); end
        tick();
        do_alloc(7'd31, 16'h5556, '0);
        n_cmp++; if (e_rcy_cnt !== '0) begin n_bad++; $display("[TB] FAIL rcy_clear_on_alloc: got %0d want 0", e_rcy_cnt); end
        nuke_rb1.valid = 1'b1;
        nuke_rb1.robid = 7'd31;
        tick();
        nuke_rb1 = '0;
        n_cmp++; if (e_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rcy_cleanup: got %b want 0", e_valid); end
    endtask

    task automatic test_async_reset();
        do_alloc(7'd40, 16'h6666, '0);
        do_issue(0, 64'h9000, 64'h9, 7'h66);
        wait_req(ok);
        exp_pkt = sb_q.pop_front();
        n_cmp++; if (!ok || e_pipe_req_pkt_mm0 !== exp_pkt) begin n_bad++; $display("[TB] FAIL areset_pkt: got %b/%h want 1/%h", ok, e_pipe_req_pkt_mm0, exp_pkt); end
        do_grant();
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (e_valid !== 1'b0 || e_pipe_req_pkt_mm0 !== '0) begin n_bad++; $display("[TB] FAIL areset_immediate: got valid=%b pkt=%h want 0/0", e_valid, e_pipe_req_pkt_mm0); end
        #2 reset = 1'b0;
        do_mm5(1'b1, 1'b0);
        n_cmp++; if (e_valid !== 1'b0 || e_dealloc !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_mm5_ignored: got valid=%b dealloc=%b want 0/0", e_valid, e_dealloc); end
    endtask

    initial begin
        $display("[TB] loadq_entry_mp bench start");
        test_reset();
        test_basic_load();
        test_stq_elders();
        test_nuke_drain();
        test_nuke_young_and_kill();
        test_recycle();
        test_async_reset();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("[TB] FAIL scoreboard_empty: got %0d left want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
